// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, saturating add/sub, logic, shift/rotate, shift-add MUL.
// Latency 1 (single-cycle ops) or WIDTH edges after accept (MUL); in_ready=~busy, flush kills the in-flight op.
module ex_stage_mc #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic             alusrc,
   input  logic             memenable,
   input  logic             pcread,
   input  logic             flag_en,
   input  logic [1:0]       branch,
   input  logic [1:0]       forward_aluin1,
   input  logic [1:0]       forward_aluin2,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] SrcData1,
   input  logic [WIDTH-1:0] SrcData2,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] forward_DstData_MEM,
   input  logic [WIDTH-1:0] forward_DstData_WB,
   output logic [WIDTH-1:0] aluout,
   output logic             out_valid,
   output logic             busy,
   output logic [2:0]       flag_out
);

   localparam int MSB = WIDTH - 1;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRA = 4'd5;
   localparam logic [3:0] OP_ROR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [SHW:0]   CNT_LAST = (SHW+1)'(WIDTH-1);
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] src_a, src_b, op_a, op_b;
   logic [WIDTH-1:0] sum, diff, res;
   logic             ovf_add, ovf_sub, res_v;
   logic [SHW-1:0]   amt, amt_neg;
   logic             accept, flag_upd, mul_done;

   logic [WIDTH-1:0] mul_a, mul_b, acc, acc_next;
   logic [SHW:0]     cnt;
   logic             mul_flag_upd;

   // Operand selection; any code with bit 1 set picks the WB value.
   always_comb begin
      case (forward_aluin1)
         2'b00:   src_a = SrcData1;
         2'b01:   src_a = forward_DstData_MEM;
         default: src_a = forward_DstData_WB;
      endcase
      case (forward_aluin2)
         2'b00:   src_b = SrcData2;
         2'b01:   src_b = forward_DstData_MEM;
         default: src_b = forward_DstData_WB;
      endcase
   end

   assign op_a = memenable ? {src_a[WIDTH-1:1], 1'b0} : src_a;
   assign op_b = alusrc ? (memenable ? {imm[WIDTH-2:0], 1'b0} : imm) : src_b;

   assign sum     = op_a + op_b;
   assign diff    = op_a - op_b;
   assign ovf_add = (op_a[MSB] == op_b[MSB]) && (sum[MSB]  != op_a[MSB]);
   assign ovf_sub = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
   assign amt     = op_b[SHW-1:0];
   // WIDTH is a power of two, so (WIDTH - amt) mod WIDTH is simply -amt.
   assign amt_neg = -amt;

   always_comb begin
      res   = op_b;
      res_v = 1'b0;
      case (aluop)
         OP_ADD: begin
            res   = ovf_add ? (op_a[MSB] ? SAT_NEG : SAT_POS) : sum;
            res_v = ovf_add;
         end
         OP_SUB: begin
            res   = ovf_sub ? (op_a[MSB] ? SAT_NEG : SAT_POS) : diff;
            res_v = ovf_sub;
         end
         OP_XOR:  res = op_a ^ op_b;
         OP_AND:  res = op_a & op_b;
         OP_SLL:  res = op_a << amt;
         OP_SRA:  res = $signed(op_a) >>> amt;
         OP_ROR:  res = (op_a >> amt) | (op_a << amt_neg);
         default: res = op_b;
      endcase
   end

   assign accept   = in_valid && !busy && !flush;
   assign flag_upd = flag_en && (branch == 2'b00) && !pcread;
   assign mul_done = (cnt == CNT_LAST);
   assign acc_next = acc + (mul_b[0] ? mul_a : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && aluop == OP_MUL) state_nxt = S_MUL;
         S_MUL:   if (flush || mul_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_MUL);
      in_ready = !busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aluout       <= '0;
         out_valid    <= 1'b0;
         flag_out     <= 3'b000;
         mul_a        <= '0;
         mul_b        <= '0;
         acc          <= '0;
         cnt          <= '0;
         mul_flag_upd <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            cnt <= '0;
         end else if (accept) begin
            if (aluop == OP_MUL) begin
               mul_a        <= op_a;
               mul_b        <= op_b;
               acc          <= '0;
               cnt          <= '0;
               mul_flag_upd <= flag_upd;
            end else begin
               aluout    <= res;
               out_valid <= 1'b1;
               if (flag_upd) begin
                  if (aluop == OP_ADD || aluop == OP_SUB) begin
                     flag_out[2] <= res[MSB];
                     flag_out[1] <= res_v;
                  end
                  if (aluop <= OP_ROR) flag_out[0] <= (res == '0);
               end
            end
         end else if (busy) begin
            // One multiplier bit consumed per edge, LSB first.
            acc   <= acc_next;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            if (mul_done) begin
               cnt       <= '0;
               aluout    <= acc_next;
               out_valid <= 1'b1;
               if (mul_flag_upd) flag_out[0] <= (acc_next == '0);
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (8..64, power of 2).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  new operation presented this cycle.
REQ-006 SHALL have port in_ready  output  1  stage can accept; equals ~busy.
REQ-007 SHALL have port flush  input  1  synchronous kill of in-flight operation.
REQ-008 SHALL have port alusrc, memenable, pcread, flag_en  input  1 each  operand select, address mode, PC-read op, flag write enable.
REQ-009 SHALL have port branch  input  2  nonzero marks a branch op.
REQ-010 SHALL have port forward_aluin1, forward_aluin2  input  2 each  operand source: 00 regfile, 01 MEM, 1x WB.
REQ-011 SHALL have port aluop  input  4  operation code.
REQ-012 SHALL have port SrcData1, SrcData2, imm, forward_DstData_MEM, forward_DstData_WB  input  WIDTH each  operand sources.
REQ-013 SHALL have port aluout  output  WIDTH  registered result.
REQ-014 SHALL have port out_valid  output  1  one-cycle pulse, aluout valid.
REQ-015 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-016 SHALL have port flag_out  output  3  registered flags {N,V,Z}.

Function
REQ-017 Operand A SHALL be the forward_aluin1-selected source; ANDed with ~1 (LSB cleared) when memenable=1.
REQ-018 Operand B SHALL be imm when alusrc=1 (imm<<1 when memenable=1 also), else the forward_aluin2-selected source.
REQ-019 Accept SHALL occur at a rising edge with in_valid=1 and busy=0; in_valid while busy is ignored, upstream holds.
REQ-020 aluop 0 ADD, 1 SUB (A-B): saturating; positive overflow -> 0x7F..F, negative overflow -> 0x80..0, V=1 on saturation.
REQ-021 aluop 2 XOR, 3 AND, 4 SLL, 5 SRA, 6 ROR; shift/rotate amount = B[SHW-1:0]; amount 0 returns A.
REQ-022 aluop 7 MUL: low WIDTH bits of unsigned A*B, iterative shift-add, one multiplier bit per cycle.
REQ-023 aluop 8..15 SHALL pass B unchanged, no flag change.
REQ-024 Single-cycle ops (0-6, 8-15): aluout registered at accept edge, out_valid=1 for the following cycle only (latency 1).
REQ-025 MUL: operands captured at accept edge k; busy=1 after edge k; WIDTH iteration edges k+1..k+WIDTH; aluout loaded at edge k+WIDTH; busy=0 and out_valid=1 after edge k+WIDTH.
REQ-026 Iteration counter SHALL be SHW+1 bits, count 0..WIDTH-1, no wrap beyond completion.
REQ-027 Flags SHALL update only at the edge aluout is loaded, only if flag_en (captured at accept) =1 and branch==0 and pcread==0.
REQ-028 N and V update on ADD/SUB only (N=aluout MSB); Z=(aluout==0) updates on ops 0-7; other flags hold.
REQ-029 flush=1 at an edge SHALL: abort MUL (busy->0), suppress out_valid and flag update for that op, leave aluout and flags unchanged; no accept occurs that edge.
REQ-030 flush with busy=0 SHALL suppress the accept of a simultaneously presented operation.
REQ-031 After MUL completion, a new op MAY be accepted at edge k+WIDTH+1 (in_ready high that cycle); no back-to-back at k+WIDTH.
REQ-032 Illegal states SHALL not exist: counter only advances while busy.

Reset
REQ-033 rst=1 SHALL immediately force aluout=0, out_valid=0, busy=0, flag_out=000, counter=0, independent of clk.
REQ-034 rst asserted mid-MUL SHALL discard the operation; no out_valid after release.
REQ-035 First accept SHALL be possible at the first rising edge with rst=0.

Verification (WIDTH=16)
REQ-036 ADD 0x7FFF+0x0001, flag_en=1 -> aluout=0x7FFF, out_valid 1 cycle later, flags N=0,V=1,Z=0.
REQ-037 SUB 0x0005-0x0005 via forward_aluin1=01 (MEM=0x0005) -> aluout=0x0000, Z=1, N=0, V=0.
REQ-038 MUL 0x0012*0x0034 -> busy 16 cycles, in_ready=0, aluout=0x03A8 with out_valid after edge k+16; in_valid during busy ignored.
REQ-039 memenable=1, alusrc=1, A=0x1003, imm=0x0004 ADD -> aluout=0x100A; branch=01 same op -> flags unchanged.
REQ-040 MUL started then flush at edge k+5 -> busy=0 next cycle, no out_valid, aluout and flags unchanged; rst mid-MUL -> all outputs 0 asynchronously.
